// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Host-side bundle of the UART receive controller: the received character,
// its status flags, the busy indication and the read-acknowledge pulse.
//
// Signals:
//   clr_rdy  host -> ctrl  single-cycle pulse from the host read
//   rx_data  ctrl -> host  received character
//   rx_rdy   ctrl -> host  character available
//   perr     ctrl -> host  parity error
//   ferr     ctrl -> host  framing error
//   ovf      ctrl -> host  overrun
//   busy     ctrl -> host  receiver is inside a frame
//
// Modports:
//   master  used by the receive controller
//   slave   used by the CPU-side read/status logic
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       perr;
    logic       ferr;
    logic       ovf;
    logic       busy;

    modport master (
        input  clr_rdy,
        output rx_data,
        output rx_rdy,
        output perr,
        output ferr,
        output ovf,
        output busy
    );

    modport slave (
        output clr_rdy,
        input  rx_data,
        input  rx_rdy,
        input  perr,
        input  ferr,
        input  ovf,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive controller. Uses the bit-period counts from the baud rate
// decoder to detect a start bit, validate it at mid-bit, then sample the
// data, optional parity and stop bits of each frame. The received byte and
// its status flags are presented to the host through uart_rx_ctrl_if.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   k        full bit period in clk cycles
//   k_div2   half bit period in clk cycles
//   rx       serial data in, idle high
//   eight    1 = 8 data bits, 0 = 7 data bits
//   pen      parity enable
//   ohel     parity sense: 1 = odd, 0 = even
//   host     uart_rx_ctrl_if.master (clr_rdy in; rx_data, rx_rdy, perr,
//            ferr, ovf, busy out)
//
// Parameters:
//   CW       width of k/k_div2 and of the bit-time counter
//
// Build option:
//   UART_RX_SYNC_EN  when defined, rx passes through a 2-flop synchronizer
//                    (reset to 1) before the state machine; all latencies
//                    grow by 2 cycles. When undefined, rx must already be
//                    synchronous to clk.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] k,
    input  logic [CW-1:0] k_div2,
    input  logic          rx,
    input  logic          eight,
    input  logic          pen,
    input  logic          ohel,
    uart_rx_ctrl_if.master host
);

    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_s;

    logic [CW-1:0] k_lat;
    logic [CW-1:0] kd2_lat;
    logic          eight_lat;
    logic          pen_lat;
    logic          ohel_lat;

    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    logic [CW-1:0] target_eff;
    logic          btu;

    logic [3:0]    bit_cnt;
    logic [3:0]    n_bits;
    logic [8:0]    shreg;

    logic          start_det;
    logic          load;
    logic [7:0]    data_bits;
    logic          parity_bit;
    logic          parity_bad;

    logic [7:0]    rx_data_q;
    logic          rx_rdy_q;
    logic          perr_q;
    logic          ferr_q;
    logic          ovf_q;
    logic          busy_q;

`ifdef UART_RX_SYNC_EN
    // Two-flop synchronizer; both stages reset to the idle level so reset
    // release never looks like a start bit.
    logic [1:0] sync_ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], rx};
        end
    end

    assign rx_s = sync_ff[1];
`else
    assign rx_s = rx;
`endif

    assign start_det = (state == IDLE) && !rx_s;

    // Frame configuration is captured when the start bit is first seen so
    // that host writes during a frame only affect the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_lat     <= '0;
            kd2_lat   <= '0;
            eight_lat <= 1'b0;
            pen_lat   <= 1'b0;
            ohel_lat  <= 1'b0;
        end else if (start_det) begin
            k_lat     <= k;
            kd2_lat   <= k_div2;
            eight_lat <= eight;
            pen_lat   <= pen;
            ohel_lat  <= ohel;
        end
    end

    // Half a bit to reach mid-start, full bits afterwards. A zero target
    // would never match target-1, so it is promoted to 1.
    assign target     = (state == START) ? kd2_lat : k_lat;
    assign target_eff = (target == '0) ? ONE : target;
    assign btu        = (state != IDLE) && (cnt == (target_eff - ONE));

    assign n_bits = (eight_lat ? 4'd8 : 4'd7) + {3'b000, pen_lat};

    // Bit-time counter: parked at 0 in IDLE, wraps on every btu so each
    // interval is exactly target cycles long.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state == IDLE) || btu) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
        end
    end

    // Next-state logic. The final data/parity sample and the move to STOP
    // happen on the same btu.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (btu) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (btu && (bit_cnt == (n_bits - 4'd1))) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (btu) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Data and parity bits land at their bit index, LSB first, so the
    // parity bit sits at index 7 or 8 depending on the character length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 4'd0;
            shreg   <= '0;
        end else if ((state == START) && btu) begin
            bit_cnt <= 4'd0;
        end else if ((state == DATA) && btu) begin
            shreg[bit_cnt] <= rx_s;
            bit_cnt        <= bit_cnt + 4'd1;
        end
    end

    assign load       = (state == STOP) && btu;
    assign data_bits  = eight_lat ? shreg[7:0] : {1'b0, shreg[6:0]};
    assign parity_bit = eight_lat ? shreg[8] : shreg[7];
    assign parity_bad = pen_lat & (parity_bit != ((^data_bits) ^ ohel_lat));

    // Host-visible character and flags. A load takes priority over a
    // coincident clr_rdy; in that case the old character was read on this
    // very cycle, so it does not count as an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q <= 8'h00;
            rx_rdy_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (load) begin
            rx_data_q <= data_bits;
            rx_rdy_q  <= 1'b1;
            ferr_q    <= ~rx_s;
            perr_q    <= parity_bad;
            ovf_q     <= rx_rdy_q & ~host.clr_rdy;
        end else if (host.clr_rdy) begin
            rx_rdy_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end
    end

    assign host.rx_data = rx_data_q;
    assign host.rx_rdy  = rx_rdy_q;
    assign host.perr    = perr_q;
    assign host.ferr    = ferr_q;
    assign host.ovf     = ovf_q;
    assign host.busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. Stimulus tasks serialise directed
// frames onto rx and push the hand-derived expected result into a queue;
// an independent monitor pops one entry whenever busy falls and compares
// the character, flags and frame latency.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int CW = 20;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] k;
    logic [CW-1:0] k_div2;
    logic          rx;
    logic          eight;
    logic          pen;
    logic          ohel;

    uart_rx_ctrl_if host_if();

    uart_rx_ctrl #(.CW(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .k      (k),
        .k_div2 (k_div2),
        .rx     (rx),
        .eight  (eight),
        .pen    (pen),
        .ohel   (ohel),
        .host   (host_if.master)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [7:0]  data;
        logic        rdy;
        logic        perr;
        logic        ferr;
        logic        ovf;
        int unsigned start_cyc;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model of the host-visible registers.
    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovf  = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_expect(input int id, input int unsigned start_cyc,
                               input int unsigned lat);
        exp_t e;
        e.id        = id;
        e.data      = m_data;
        e.rdy       = m_rdy;
        e.perr      = m_perr;
        e.ferr      = m_ferr;
        e.ovf       = m_ovf;
        e.start_cyc = start_cyc;
        e.lat       = lat;
        sb.push_back(e);
    endtask

    // Monitor: every busy fall ends either a frame load or a false start.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !host_if.busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_end: busy fell at cycle %0d, expected no frame end", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output($sformatf("f%0d latency", e.id), cyc - e.start_cyc, e.lat);
                    check_output($sformatf("f%0d rx_data", e.id), {24'h0, host_if.rx_data}, {24'h0, e.data});
                    check_output($sformatf("f%0d rx_rdy", e.id), {31'h0, host_if.rx_rdy}, {31'h0, e.rdy});
                    check_output($sformatf("f%0d perr", e.id), {31'h0, host_if.perr}, {31'h0, e.perr});
                    check_output($sformatf("f%0d ferr", e.id), {31'h0, host_if.ferr}, {31'h0, e.ferr});
                    check_output($sformatf("f%0d ovf", e.id), {31'h0, host_if.ovf}, {31'h0, e.ovf});
                end
            end
            prev_busy = host_if.busy;
        end
    end

    // Serialise one frame, one clock per iteration on the falling edge.
    // A low stop bit is only held just past its sample point so that the
    // line is idle again before the receiver re-arms.
    task automatic send_frame(input int id, input int kv, input int kd2v,
                              input logic e8, input logic pn, input logic od,
                              input logic [7:0] d, input logic force_par,
                              input logic par_val, input logic stop_val,
                              input logic clr_at_load, input int k_mid);
        logic [10:0] bits;
        logic [7:0]  dm;
        logic        par;
        int          nd;
        int          nb;
        int          lat;
        int          total;
        nd  = e8 ? 8 : 7;
        dm  = e8 ? d : {1'b0, d[6:0]};
        par = force_par ? par_val : ((^dm) ^ od);
        nb  = nd + (pn ? 1 : 0);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) bits[1 + i] = d[i];
        if (pn) bits[1 + nd] = par;
        bits[1 + nb] = stop_val;
        lat   = kd2v + nb * kv + kv + SYNC_LAT;
        total = (nb + 1) * kv + (stop_val ? kv : kd2v + 1);

        @(negedge clk);
        k      = CW'(kv);
        k_div2 = CW'(kd2v);
        eight  = e8;
        pen    = pn;
        ohel   = od;

        m_ovf  = m_rdy & ~clr_at_load;
        m_rdy  = 1'b1;
        m_data = dm;
        m_perr = pn & (par != ((^dm) ^ od));
        m_ferr = ~stop_val;

        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            rx = bits[c / kv];
            host_if.clr_rdy = clr_at_load && (c == lat);
            if ((k_mid != 0) && (c == 300)) k = CW'(k_mid);
            if (c == 0) push_expect(id, cyc + 1, lat);
        end
        @(negedge clk);
        rx = 1'b1;
        host_if.clr_rdy = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        host_if.clr_rdy = 1'b1;
        @(negedge clk);
        host_if.clr_rdy = 1'b0;
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check_output(name, {18'h0, host_if.rx_data, host_if.rx_rdy, host_if.perr,
                            host_if.ferr, host_if.ovf, host_if.busy}, 32'h0);
    endtask

    initial begin
        rx              = 1'b1;
        k               = CW'(109);
        k_div2          = CW'(54);
        eight           = 1'b1;
        pen             = 1'b0;
        ohel            = 1'b0;
        host_if.clr_rdy = 1'b0;

        // Reset state, held and just after release.
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        // 8N1 0x55.
        send_frame(1, 109, 54, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        clr_pulse();

        // 8E1 0xA3 with a wrong parity bit.
        send_frame(2, 109, 54, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        clr_pulse();

        // 7N1 0x7F with the stop bit low, then a host read.
        send_frame(3, 217, 108, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        clr_pulse();
        check_output("clr rx_rdy", {31'h0, host_if.rx_rdy}, 32'h0);
        check_output("clr ferr", {31'h0, host_if.ferr}, 32'h0);
        check_output("clr rx_data held", {24'h0, host_if.rx_data}, 32'h7F);

        // Back-to-back without a read: overrun.
        send_frame(4, 109, 54, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send_frame(5, 109, 54, 1'b1, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        clr_pulse();

        // Back-to-back with the read landing on the second load edge.
        send_frame(6, 109, 54, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send_frame(7, 109, 54, 1'b1, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        repeat (20) @(negedge clk);
        check_output("late rx_rdy", {31'h0, host_if.rx_rdy}, 32'h1);

        // False start: rx low for 20 cycles only.
        @(negedge clk);
        k      = CW'(109);
        k_div2 = CW'(54);
        @(negedge clk);
        rx = 1'b0;
        push_expect(8, cyc + 1, 54 + SYNC_LAT);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (80) @(negedge clk);

        // k changes to 868 mid-frame; timing must stay at 109.
        send_frame(9, 109, 54, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 868);

        // Asynchronous reset while in DATA.
        @(negedge clk);
        k      = CW'(109);
        k_div2 = CW'(54);
        rx     = 1'b0;
        repeat (109) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check_output("busy in data", {31'h0, host_if.busy}, 32'h1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset_outputs");
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;

        // Next frame after reset: 8O1 0xC9 with correct parity.
        send_frame(10, 109, 54, 1'b1, 1'b1, 1'b1, 8'hC9, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        for (int i = 0; (i < 5000) && (sb.size() != 0); i++) @(negedge clk);
        check_output("scoreboard_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive controller. Consumes the bit-period counts k and k_div2 produced by the baud rate decoder and sequences each frame: start detect, mid-start validation, data/parity/stop sampling.
- Presents the received byte with ready and error flags to the host interface.
- Sits between the serial input pin and the CPU-side read/status logic.

Parameters:
- CW, 20, width of the k/k_div2 inputs and of the internal bit-time counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- k  input  CW  full bit period in clk cycles, from the baud rate decoder
- k_div2  input  CW  half bit period in clk cycles, from the baud rate decoder
- rx  input  1  serial data in, idle high
- eight  input  1  1 = 8 data bits, 0 = 7 data bits
- pen  input  1  parity enable
- ohel  input  1  parity sense: 1 = odd, 0 = even
- clr_rdy  input  1  single-cycle pulse from the host read; clears ready and flags
- rx_data  output  8  received character
- rx_rdy  output  1  character available
- perr  output  1  parity error
- ferr  output  1  framing error (stop bit sampled low)
- ovf  output  1  overrun: new character loaded while rx_rdy still set
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset is asynchronous and active-high. During reset: state = IDLE, all counters = 0, rx_data = 0, rx_rdy = perr = ferr = ovf = busy = 0.
- Bit-time counter:
  - Counts up once per clk.
  - btu fires when the count equals target-1, then the count clears. Each interval is therefore exactly target cycles.
  - The counter is held at 0 in IDLE.
  - A target of 0 is treated as 1.
- Frame latching: on the IDLE->START transition, latch k, k_div2, eight, pen and ohel. Changes to these inputs mid-frame have no effect until the next frame.
- States:
  - IDLE: rx == 0 sampled at a clk edge -> START.
  - START: target = k_div2. On btu:
    - rx == 1 -> IDLE (false start, no flags change).
    - rx == 0 -> DATA, bit count = 0.
  - DATA: target = k. On btu, sample rx into the frame shift register, LSB first, and increment bit count. When bit count reaches N = (eight ? 8 : 7) + (pen ? 1 : 0) -> STOP.
  - STOP: target = k. On btu:
    - rx_data <= data bits, with rx_data[7] = 0 when eight = 0.
    - rx_rdy <= 1.
    - ferr <= ~rx.
    - perr <= pen & (parity_bit != (^data ^ ohel)).
    - ovf <= rx_rdy (value before this edge).
    - Next state is IDLE.
- Latency: rx_rdy rises exactly k_div2 + N*k + k cycles after the edge that first samples rx low in IDLE.
- Flag clearing:
  - clr_rdy clears rx_rdy, perr, ferr and ovf on the next edge.
  - If clr_rdy coincides with the STOP load, the load wins: rx_rdy = 1, and ovf = 0 because the old character was read that cycle.
- A new frame may begin on the cycle after STOP returns to IDLE. rx_data is held until the next load.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx passes through a 2-flop synchronizer (both flops reset to 1) before the state machine. All latencies grow by 2 cycles.
- Undefined: rx is used directly. The designer guarantees rx is synchronous to clk.

Test Plan:
- k=109, k_div2=54, eight=1, pen=0, send 0x55 8N1 -> rx_rdy rises 1035 cycles after the first low sample; rx_data=0x55; perr=ferr=ovf=0.
- Same k, eight=1, pen=1, ohel=0, send 0xA3 with the parity bit set incorrectly to 1 -> rx_rdy=1, rx_data=0xA3, perr=1, ferr=0.
- k=217, k_div2=108, eight=0, pen=0, send 0x7F with the stop bit held low -> rx_data=0x7F, ferr=1. A 1-cycle clr_rdy then clears rx_rdy and ferr on the next edge.
- Send two back-to-back frames (0x12, 0x34) with no clr_rdy -> after the second frame, rx_data=0x34 and ovf=1. Repeat with clr_rdy pulsed on the same edge as the second load -> rx_rdy=1, ovf=0.
- k=109, k_div2=54, pulse rx low for 20 cycles -> START aborts at btu, state returns to IDLE, busy falls, no flag changes. Change k to 868 mid-frame -> the frame still completes with k=109 timing.
- Assert reset during DATA -> all outputs 0 immediately, without waiting for clk. The next valid frame is received correctly.
